t04_memory_handler: RTL

- Sits directly downstream of the t04 datapath's request unit; turns its combined fetch/load/store request into single transactions on the team's word-wide request/acknowledge memory bus.
- Returns i_ack, d_ack, instruction and memload to the datapath.
- Serialises requests: one outstanding transaction at a time.
- Guarantees a single-cycle acknowledge pulse per completed access.
- A bounded timeout keeps the core from hanging on a dead target.

---
 rtl/t04_memory_handler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/t04_memory_handler.sv
// t04_memory_handler: turns the datapath's fetch/load/store request into one
// word-wide request/acknowledge bus transaction at a time. Every access ends
// with exactly one single-cycle i_ack or d_ack pulse. A bounded timeout
// force-completes an access when the target never answers.
module t04_memory_handler #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] final_address,
    input  logic [31:0] mem_store,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        i_ack,
    output logic        d_ack,
    output logic [31:0] instruction,
    output logic [31:0] memload,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        timeout_err
);

    // Counter only has to reach TIMEOUT_CYCLES-1; the access leaves REQ there,
    // so it never wraps.
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        KIND_FETCH,
        KIND_LOAD,
        KIND_STORE
    } kind_t;

    state_t           state;
    kind_t            kind;
    logic [CNT_W-1:0] cnt;

    // Only whole-word accesses are ever issued.
    assign bus_sel = 4'hF;

    // Single FSM: sample request in IDLE, run the bus handshake in REQ,
    // emit the one-cycle Moore acknowledge in ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            kind        <= KIND_FETCH;
            cnt         <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_wdata   <= 32'h0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            timeout_err <= 1'b0;
            instruction <= NOP_WORD;
            memload     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    // Stores win over loads when both flags are raised.
                    state    <= REQ;
                    bus_req  <= 1'b1;
                    bus_addr <= {final_address[31:2], 2'b00};
                    cnt      <= '0;
                    if (MemWrite) begin
                        kind      <= KIND_STORE;
                        bus_we    <= 1'b1;
                        bus_wdata <= mem_store;
                    end else if (MemRead) begin
                        kind   <= KIND_LOAD;
                        bus_we <= 1'b0;
                    end else begin
                        kind   <= KIND_FETCH;
                        bus_we <= 1'b0;
                    end
                end

                REQ: begin
                    if (bus_ack) begin
                        // A real acknowledge beats a coinciding timeout.
                        if (kind == KIND_FETCH) begin
                            instruction <= bus_rdata;
                        end else if (kind == KIND_LOAD) begin
                            memload <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= ACK;
                        i_ack   <= (kind == KIND_FETCH);
                        d_ack   <= (kind != KIND_FETCH);
                    end else if (cnt == CNT_LAST) begin
                        // Dead target: hand the core a harmless value.
                        if (kind == KIND_FETCH) begin
                            instruction <= NOP_WORD;
                        end else if (kind == KIND_LOAD) begin
                            memload <= 32'h0;
                        end
                        timeout_err <= 1'b1;
                        bus_req     <= 1'b0;
                        cnt         <= '0;
                        state       <= ACK;
                        i_ack       <= (kind == KIND_FETCH);
                        d_ack       <= (kind != KIND_FETCH);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ACK: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
